// File: rtl/useq_controller.sv
// useq_controller: microprogrammed control unit.
// A writable control store holds microwords that are sequenced one per cycle.
// Each microword carries a sequencing opcode, a condition select, a memory-wait
// flag, a branch target and the control word driven to the datapath. An opcode
// dispatch table, a micro-return stack and a memory-ready stall are supported.
module useq_controller #(
    parameter  int CW_W    = 25,
    parameter  int UADDR_W = 5,
    parameter  int ISR_W   = 16,
    parameter  int OP_W    = 4,
    parameter  int STACK_D = 4,
    localparam int MW      = CW_W + UADDR_W + 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [ISR_W-1:0]   isr,
    input  logic [3:0]         cond,
    input  logic               mem_ready,
    input  logic               us_we,
    input  logic [UADDR_W-1:0] us_waddr,
    input  logic [MW-1:0]      us_wdata,
    input  logic               dt_we,
    input  logic [OP_W-1:0]    dt_waddr,
    input  logic [UADDR_W-1:0] dt_wdata,
    output logic [CW_W-1:0]    ctrl,
    output logic [UADDR_W-1:0] upc,
    output logic               valid,
    output logic               stack_err
);

    // sp counts 0..STACK_D, so it needs one more code than the stack has entries
    localparam int SP_W  = $clog2(STACK_D + 1);
    localparam int IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;
    localparam int STORE_D = 2 ** UADDR_W;
    localparam int DISP_D  = 2 ** OP_W;
    localparam int STK_E   = 2 ** IDX_W;

    typedef enum logic [2:0] {
        SEQ_NEXT  = 3'd0,
        SEQ_JMP   = 3'd1,
        SEQ_DISP  = 3'd2,
        SEQ_BRC   = 3'd3,
        SEQ_CALL  = 3'd4,
        SEQ_RET   = 3'd5,
        SEQ_FETCH = 3'd6,
        SEQ_RSVD  = 3'd7
    } seqOp_e;

    logic [MW-1:0]      store_q [STORE_D];
    logic [UADDR_W-1:0] dispatch_q [DISP_D];
    logic [UADDR_W-1:0] stack_q [STK_E];

    logic [MW-1:0]      uir_q, uir_d;
    logic [UADDR_W-1:0] upc_q, upc_d;
    logic               valid_q, valid_d;
    logic [SP_W-1:0]    sp_q, sp_d;
    logic               stackErr_q, stackErr_d;

    // decoded fields of the held microword
    seqOp_e             seqOp;
    logic [1:0]         condSel;
    logic               waitBit;
    logic [UADDR_W-1:0] target;

    logic [UADDR_W-1:0] upcPlusOne;
    logic [UADDR_W-1:0] nextAddr;
    logic [OP_W-1:0]    opcode;
    logic               stackFull;
    logic               stackEmpty;
    logic               stall;
    logic               advance;
    logic               pushEn;
    logic [IDX_W-1:0]   pushIdx;
    logic [IDX_W-1:0]   popIdx;
    logic               unusedIsrBits;

    assign seqOp   = seqOp_e'(uir_q[MW-1 -: 3]);
    assign condSel = uir_q[MW-4 -: 2];
    assign waitBit = uir_q[MW-6];
    assign target  = uir_q[CW_W +: UADDR_W];

    assign upcPlusOne = upc_q + UADDR_W'(1);
    assign opcode     = isr[ISR_W-1 -: OP_W];
    assign unusedIsrBits = ^isr[ISR_W-OP_W-1:0];

    assign stackFull  = (sp_q == SP_W'(STACK_D));
    assign stackEmpty = (sp_q == '0);
    assign pushIdx    = IDX_W'(sp_q);
    assign popIdx     = IDX_W'(sp_q - SP_W'(1));

    assign stall   = waitBit && !mem_ready;
    assign advance = run && valid_q && !stall;

    // next micro-address selection from the sequencing field of the held word
    always_comb begin
        nextAddr = upcPlusOne;
        case (seqOp)
            SEQ_NEXT:  nextAddr = upcPlusOne;
            SEQ_JMP:   nextAddr = target;
            SEQ_DISP:  nextAddr = dispatch_q[opcode];
            SEQ_BRC:   nextAddr = cond[condSel] ? target : upcPlusOne;
            SEQ_CALL:  nextAddr = target;
            SEQ_RET:   nextAddr = stackEmpty ? '0 : stack_q[popIdx];
            SEQ_FETCH: nextAddr = '0;
            SEQ_RSVD:  nextAddr = '0;
            default:   nextAddr = '0;
        endcase
    end

    // next-state for the sequencer registers: start, advance, or hold
    always_comb begin
        uir_d      = uir_q;
        upc_d      = upc_q;
        valid_d    = valid_q;
        sp_d       = sp_q;
        stackErr_d = stackErr_q;
        pushEn     = 1'b0;
        if (run && !valid_q) begin
            upc_d   = '0;
            uir_d   = store_q[0];
            valid_d = 1'b1;
        end else if (advance) begin
            upc_d = nextAddr;
            uir_d = store_q[nextAddr];
            if (seqOp == SEQ_CALL) begin
                if (stackFull) begin
                    stackErr_d = 1'b1;
                end else begin
                    pushEn = 1'b1;
                    sp_d   = sp_q + SP_W'(1);
                end
            end else if (seqOp == SEQ_RET) begin
                if (stackEmpty) begin
                    stackErr_d = 1'b1;
                end else begin
                    sp_d = sp_q - SP_W'(1);
                end
            end
        end
    end

    // sequencer state register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            uir_q      <= '0;
            upc_q      <= '0;
            valid_q    <= 1'b0;
            sp_q       <= '0;
            stackErr_q <= 1'b0;
        end else begin
            uir_q      <= uir_d;
            upc_q      <= upc_d;
            valid_q    <= valid_d;
            sp_q       <= sp_d;
            stackErr_q <= stackErr_d;
        end
    end

    // return-address push; stack contents need no reset since sp guards them
    always_ff @(posedge clk) begin
        if (!reset && pushEn) begin
            stack_q[pushIdx] <= upcPlusOne;
        end
    end

    // control store and dispatch table are writable only while halted
    always_ff @(posedge clk) begin
        if (!reset && !run) begin
            if (us_we) begin
                store_q[us_waddr] <= us_wdata;
            end
            if (dt_we) begin
                dispatch_q[dt_waddr] <= dt_wdata;
            end
        end
    end

    assign ctrl      = (valid_q && run) ? uir_q[CW_W-1:0] : '0;
    assign upc       = upc_q;
    assign valid     = valid_q;
    assign stack_err = stackErr_q;

endmodule

// File: tb/tb_useq_controller.sv
// tb_useq_controller: directed checks of the microprogrammed control unit.
// Each phase loads a small microprogram while halted, resets, runs, and
// compares upc / ctrl / valid / stack_err against hand-computed values.
module tb_useq_controller;

    localparam int CW_W    = 25;
    localparam int UADDR_W = 5;
    localparam int ISR_W   = 16;
    localparam int OP_W    = 4;
    localparam int STACK_D = 4;
    localparam int MW      = CW_W + UADDR_W + 6;

    localparam logic [2:0] SEQ   = 3'd0;
    localparam logic [2:0] JMP   = 3'd1;
    localparam logic [2:0] DISP  = 3'd2;
    localparam logic [2:0] BRC   = 3'd3;
    localparam logic [2:0] CALL  = 3'd4;
    localparam logic [2:0] RET   = 3'd5;
    localparam logic [2:0] FETCH = 3'd6;

    logic               clk;
    logic               reset;
    logic               run;
    logic [ISR_W-1:0]   isr;
    logic [3:0]         cond;
    logic               mem_ready;
    logic               us_we;
    logic [UADDR_W-1:0] us_waddr;
    logic [MW-1:0]      us_wdata;
    logic               dt_we;
    logic [OP_W-1:0]    dt_waddr;
    logic [UADDR_W-1:0] dt_wdata;
    logic [CW_W-1:0]    ctrl;
    logic [UADDR_W-1:0] upc;
    logic               valid;
    logic               stack_err;

    int testsRun    = 0;
    int testsFailed = 0;

    useq_controller #(
        .CW_W(CW_W), .UADDR_W(UADDR_W), .ISR_W(ISR_W), .OP_W(OP_W), .STACK_D(STACK_D)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .isr(isr), .cond(cond),
        .mem_ready(mem_ready), .us_we(us_we), .us_waddr(us_waddr),
        .us_wdata(us_wdata), .dt_we(dt_we), .dt_waddr(dt_waddr),
        .dt_wdata(dt_wdata), .ctrl(ctrl), .upc(upc), .valid(valid),
        .stack_err(stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // overall time limit so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [MW-1:0] mw(input logic [2:0] seqOp, input logic [1:0] csel,
                                         input logic wt, input logic [4:0] tgt,
                                         input logic [24:0] ctl);
        return {seqOp, csel, wt, tgt, ctl};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic writeStore(input logic [UADDR_W-1:0] a, input logic [MW-1:0] d);
        us_waddr = a;
        us_wdata = d;
        us_we    = 1'b1;
        applyStimulus(1);
        us_we    = 1'b0;
    endtask

    task automatic writeDisp(input logic [OP_W-1:0] a, input logic [UADDR_W-1:0] d);
        dt_waddr = a;
        dt_wdata = d;
        dt_we    = 1'b1;
        applyStimulus(1);
        dt_we    = 1'b0;
    endtask

    task automatic doReset();
        run   = 1'b0;
        reset = 1'b1;
        applyStimulus(1);
        reset = 1'b0;
    endtask

    task automatic checkWord(input string tag, input int expUpc, input int expCtrl);
        checkOutput({tag, " upc"}, 32'(upc), expUpc);
        checkOutput({tag, " ctrl"}, 32'(ctrl), expCtrl);
    endtask

    int stkUpc [11] = '{0, 2, 4, 6, 8, 10, 7, 5, 3, 1, 0};
    int stkErr [11] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};

    initial begin
        reset = 1'b1; run = 1'b0; isr = '0; cond = '0; mem_ready = 1'b1;
        us_we = 1'b0; us_waddr = '0; us_wdata = '0;
        dt_we = 1'b0; dt_waddr = '0; dt_wdata = '0;
        applyStimulus(2);
        checkOutput("reset upc", 32'(upc), 0);
        checkOutput("reset ctrl", 32'(ctrl), 0);
        checkOutput("reset valid", 32'(valid), 0);
        checkOutput("reset stack_err", 32'(stack_err), 0);
        reset = 1'b0;

        // basic sequencing: SEQ then FETCH loop
        writeStore(0, mw(SEQ, 0, 0, 0, 25'h41));
        writeStore(1, mw(FETCH, 0, 0, 0, 25'h20));
        doReset();
        run = 1'b1;
        #1;
        checkOutput("start ctrl before load", 32'(ctrl), 0);
        applyStimulus(1);
        checkOutput("start valid", 32'(valid), 1);
        checkWord("basic w0", 0, 'h41);
        applyStimulus(1);
        checkWord("basic w1", 1, 'h20);
        applyStimulus(1);
        checkWord("basic fetch", 0, 'h41);

        // dispatch on opcode field
        run = 1'b0;
        writeStore(1, mw(SEQ, 0, 0, 0, 25'h2));
        writeStore(2, mw(DISP, 0, 0, 0, 25'h3));
        writeStore(7, mw(FETCH, 0, 0, 0, 25'h7));
        writeStore(9, mw(FETCH, 0, 0, 0, 25'h9));
        writeDisp(4'h9, 5'h07);
        writeDisp(4'hA, 5'h09);
        isr = 16'h9000;
        doReset();
        run = 1'b1;
        applyStimulus(3);
        checkWord("disp w2", 2, 'h3);
        applyStimulus(1);
        checkWord("disp op9", 7, 'h7);
        isr = 16'hA000;
        applyStimulus(3);
        checkWord("disp w2b", 2, 'h3);
        applyStimulus(1);
        checkWord("disp opA", 9, 'h9);

        // conditional branch and address wrap
        run = 1'b0;
        writeStore(0, mw(JMP, 0, 0, 3, 25'h50));
        writeStore(3, mw(BRC, 0, 0, 5'h10, 25'h53));
        writeStore(4, mw(FETCH, 0, 0, 0, 25'h54));
        writeStore(5'h10, mw(JMP, 0, 0, 5'h1F, 25'h60));
        writeStore(5'h1F, mw(SEQ, 0, 0, 0, 25'h7F));
        cond = 4'b0001;
        doReset();
        run = 1'b1;
        applyStimulus(2);
        checkWord("brc at 3", 3, 'h53);
        applyStimulus(1);
        checkWord("brc taken", 'h10, 'h60);
        applyStimulus(1);
        checkWord("jmp 1f", 'h1F, 'h7F);
        applyStimulus(1);
        checkWord("seq wrap", 0, 'h50);
        cond = 4'b1110;
        applyStimulus(2);
        checkWord("brc not taken", 4, 'h54);

        // memory-ready stall
        run = 1'b0;
        writeStore(0, mw(SEQ, 0, 0, 0, 25'h11));
        writeStore(1, mw(SEQ, 0, 1, 0, 25'h22));
        writeStore(2, mw(FETCH, 0, 0, 0, 25'h33));
        mem_ready = 1'b0;
        doReset();
        run = 1'b1;
        applyStimulus(2);
        checkWord("stall c1", 1, 'h22);
        for (int i = 2; i <= 4; i++) begin
            applyStimulus(1);
            checkWord($sformatf("stall c%0d", i), 1, 'h22);
        end
        mem_ready = 1'b1;
        applyStimulus(1);
        checkWord("stall release", 2, 'h33);

        // nested calls with overflow, returns with underflow
        run = 1'b0;
        for (int a = 0; a <= 8; a += 2)
            writeStore(5'(a), mw(CALL, 0, 0, 5'(a + 2), 25'(32'hE00 + a)));
        for (int a = 1; a <= 7; a += 2)
            writeStore(5'(a), mw(RET, 0, 0, 0, 25'(32'hE00 + a)));
        writeStore(10, mw(RET, 0, 0, 0, 25'hE0A));
        doReset();
        run = 1'b1;
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1);
            checkWord($sformatf("stack step%0d", i), stkUpc[i], 'hE00 + stkUpc[i]);
            checkOutput($sformatf("stack_err step%0d", i), 32'(stack_err), stkErr[i]);
        end

        // halt, reload, resume
        run = 1'b0;
        writeStore(0, mw(SEQ, 0, 0, 0, 25'h100));
        writeStore(1, mw(SEQ, 0, 0, 0, 25'h101));
        writeStore(2, mw(SEQ, 0, 0, 0, 25'h102));
        writeStore(3, mw(FETCH, 0, 0, 0, 25'h103));
        doReset();
        run = 1'b1;
        applyStimulus(2);
        checkWord("halt pre", 1, 'h101);
        run = 1'b0;
        #1;
        checkOutput("halt ctrl", 32'(ctrl), 0);
        applyStimulus(1);
        checkWord("halt frozen", 1, 0);
        checkOutput("halt valid", 32'(valid), 1);
        writeStore(2, mw(SEQ, 0, 0, 0, 25'h1AA));
        writeStore(1, mw(SEQ, 0, 0, 0, 25'h1BB));
        run = 1'b1;
        #1;
        checkWord("resume held", 1, 'h101);
        applyStimulus(1);
        checkWord("resume new", 2, 'h1AA);
        us_waddr = 0;
        us_wdata = mw(FETCH, 0, 0, 0, 25'h1CC);
        us_we    = 1'b1;
        applyStimulus(1);
        us_we    = 1'b0;
        checkWord("run write w3", 3, 'h103);
        applyStimulus(1);
        checkWord("run write ignored", 0, 'h100);
        applyStimulus(1);
        checkWord("held rewrite", 1, 'h1BB);

        // reset wins over run
        reset = 1'b1;
        applyStimulus(1);
        checkOutput("reset run upc", 32'(upc), 0);
        checkOutput("reset run valid", 32'(valid), 0);
        checkOutput("reset run ctrl", 32'(ctrl), 0);
        checkOutput("reset run stack_err", 32'(stack_err), 0);
        reset = 1'b0;
        run = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
